pc_gen_hs: RTL and testbench

//  Parametrised program-counter generator for the fetch stage. Issues fetch addresses over a

---
 rtl/pc_gen_hs.sv | 114 +++++++++++
 tb/tb_pc_gen_hs.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pc_gen_hs.sv
// Fetch-stage program-counter generator: issues PCs over a valid/ready handshake,
// buffers redirects that arrive while a request is stalled, and follows pipeline flow control.
module pc_gen_hs #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned          STEP         = 4,
    parameter int unsigned          ALIGN_BITS   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jtag_reset_flag_i,
    input  logic [1:0]          flow_pc_i,
    input  logic                redirect_valid_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic                fetch_valid_o,
    input  logic                fetch_ready_i,
    output logic [PC_WIDTH-1:0] fetch_pc_o,
    output logic                redirect_pend_o,
    output logic                misalign_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_e;

    // A mask of zero (ALIGN_BITS=0) disables the alignment check without a zero-width slice.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
        (PC_WIDTH'(1) << ALIGN_BITS) - PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] STEP_W = PC_WIDTH'(STEP);

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                pend_q, pend_d;
    logic                misalign_q, misalign_d;

    logic flush, flow_work, acc, can_move, misaligned, redirect_ok;

    assign flush       = jtag_reset_flag_i | (flow_pc_i == 2'b10);
    assign flow_work   = (flow_pc_i == 2'b00);
    assign acc         = valid_q & fetch_ready_i;
    assign can_move    = acc | ~valid_q;
    assign misaligned  = redirect_valid_i & ((redirect_pc_i & ALIGN_MASK) != '0);
    assign redirect_ok = redirect_valid_i & ~misaligned;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        misalign_d = 1'b0;
        valid_d    = 1'b0;

        if (flush) begin
            pc_d    = RESET_VECTOR;
            pend_d  = 1'b0;
            state_d = BOOT;
        end else begin
            misalign_d = misaligned;

            // The PC may only move while no request is outstanding or on the accepting edge.
            if (redirect_ok) begin
                if (can_move) begin
                    pc_d   = redirect_pc_i;
                    pend_d = 1'b0;
                end else begin
                    pend_pc_d = redirect_pc_i;
                    pend_d    = 1'b1;
                end
            end else if (pend_q && can_move) begin
                pc_d   = pend_pc_q;
                pend_d = 1'b0;
            end else if (acc) begin
                pc_d = pc_q + STEP_W;
            end

            case (state_q)
                BOOT:    state_d = flow_work ? RUN : HALT;
                RUN:     if (!flow_work && can_move) state_d = HALT;
                HALT:    if (flow_work) state_d = RUN;
                default: state_d = BOOT;
            endcase
        end

        valid_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            valid_q    <= 1'b0;
            pc_q       <= RESET_VECTOR;
            pend_pc_q  <= '0;
            pend_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_q     <= pend_d;
            misalign_q <= misalign_d;
        end
    end

    assign fetch_valid_o   = valid_q;
    assign fetch_pc_o      = pc_q;
    assign redirect_pend_o = pend_q;
    assign misalign_o      = misalign_q;

endmodule

// File: tb/tb_pc_gen_hs.sv
// Directed self-checking bench for pc_gen_hs: a 32-bit instance for the main behaviour
// and an 8-bit instance sharing the same stimulus to observe PC wrap-around.
module tb_pc_gen_hs;

    localparam logic [1:0] WORK    = 2'b00;
    localparam logic [1:0] STOP    = 2'b01;

    logic        clk;
    logic        rst;
    logic        jtag;
    logic [1:0]  flow;
    logic        redirValid;
    logic [31:0] redirPc;
    logic        ready;

    logic        validO;
    logic [31:0] pcO;
    logic        pendO;
    logic        misO;

    logic        smallValidO;
    logic [7:0]  smallPcO;
    logic        smallPendO;
    logic        smallMisO;

    int total = 0;
    int bad   = 0;

    pc_gen_hs dut (
        .clk               (clk),
        .rst               (rst),
        .jtag_reset_flag_i (jtag),
        .flow_pc_i         (flow),
        .redirect_valid_i  (redirValid),
        .redirect_pc_i     (redirPc),
        .fetch_valid_o     (validO),
        .fetch_ready_i     (ready),
        .fetch_pc_o        (pcO),
        .redirect_pend_o   (pendO),
        .misalign_o        (misO)
    );

    pc_gen_hs #(.PC_WIDTH(8)) dutSmall (
        .clk               (clk),
        .rst               (rst),
        .jtag_reset_flag_i (jtag),
        .flow_pc_i         (flow),
        .redirect_valid_i  (redirValid),
        .redirect_pc_i     (redirPc[7:0]),
        .fetch_valid_o     (smallValidO),
        .fetch_ready_i     (ready),
        .fetch_pc_o        (smallPcO),
        .redirect_pend_o   (smallPendO),
        .misalign_o        (smallMisO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge that consumes them.
    task automatic applyStimulus(input logic j, input logic [1:0] f, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        jtag       = j;
        flow       = f;
        redirValid = rv;
        redirPc    = rpc;
        ready      = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic v, input logic [31:0] pc,
                              input logic p, input logic m);
        checkOutput({tag, ".valid"}, {31'b0, validO}, {31'b0, v});
        checkOutput({tag, ".pc"}, pcO, pc);
        checkOutput({tag, ".pend"}, {31'b0, pendO}, {31'b0, p});
        checkOutput({tag, ".mis"}, {31'b0, misO}, {31'b0, m});
    endtask

    initial begin
        rst = 1'b1; jtag = 1'b0; flow = WORK; redirValid = 1'b0; redirPc = '0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkState("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        checkState("bubble", 1'b0, 32'h0, 1'b0, 1'b0);

        // Sequential fetch after the boot bubble.
        applyStimulus(0, WORK, 0, 0, 1); checkState("seq0", 1, 32'h00, 0, 0);
        applyStimulus(0, WORK, 0, 0, 1); checkState("seq4", 1, 32'h04, 0, 0);
        applyStimulus(0, WORK, 0, 0, 1); checkState("seq8", 1, 32'h08, 0, 0);
        applyStimulus(0, WORK, 0, 0, 1); checkState("seqC", 1, 32'h0C, 0, 0);
        applyStimulus(0, WORK, 0, 0, 1); checkState("seq10", 1, 32'h10, 0, 0);

        // Redirect while stalled is buffered and applied on acceptance.
        applyStimulus(0, WORK, 1, 32'h80, 0); checkState("stallRedir", 1, 32'h10, 1, 0);
        applyStimulus(0, WORK, 0, 0, 0);      checkState("stallHold", 1, 32'h10, 1, 0);
        applyStimulus(0, WORK, 0, 0, 1);      checkState("pendApply", 1, 32'h80, 0, 0);
        applyStimulus(0, WORK, 0, 0, 1);      checkState("after80", 1, 32'h84, 0, 0);

        // A newer buffered redirect overwrites the older one.
        applyStimulus(0, WORK, 1, 32'h80, 0); checkState("twoRedirA", 1, 32'h84, 1, 0);
        applyStimulus(0, WORK, 1, 32'h90, 0); checkState("twoRedirB", 1, 32'h84, 1, 0);
        applyStimulus(0, WORK, 0, 0, 1);      checkState("newestWins", 1, 32'h90, 0, 0);
        applyStimulus(0, WORK, 0, 0, 1);      checkState("after90", 1, 32'h94, 0, 0);

        // Misaligned redirect is dropped and flagged for a single cycle.
        applyStimulus(0, WORK, 1, 32'h102, 1); checkState("misDrop", 1, 32'h98, 0, 1);
        applyStimulus(0, WORK, 0, 0, 1);       checkState("misPulse", 1, 32'h9C, 0, 0);

        // STOP while stalled holds the request until accepted, then halts.
        applyStimulus(0, STOP, 0, 0, 0); checkState("stopStall1", 1, 32'h9C, 0, 0);
        applyStimulus(0, STOP, 0, 0, 0); checkState("stopStall2", 1, 32'h9C, 0, 0);
        applyStimulus(0, STOP, 0, 0, 1); checkState("stopAcc", 0, 32'hA0, 0, 0);
        applyStimulus(0, STOP, 0, 0, 1); checkState("halted", 0, 32'hA0, 0, 0);
        applyStimulus(0, WORK, 0, 0, 1); checkState("resume", 1, 32'hA0, 0, 0);
        applyStimulus(0, WORK, 0, 0, 1); checkState("resumeSeq", 1, 32'hA4, 0, 0);

        // JTAG restart flushes a pending redirect and reinserts the bubble.
        applyStimulus(0, WORK, 1, 32'h200, 0); checkState("jtagPrep", 1, 32'hA4, 1, 0);
        applyStimulus(1, WORK, 0, 0, 0);       checkState("jtagFlush", 0, 32'h0, 0, 0);
        applyStimulus(0, WORK, 0, 0, 1);       checkState("jtagBubble", 1, 32'h0, 0, 0);
        applyStimulus(0, WORK, 0, 0, 1);       checkState("jtagSeq", 1, 32'h4, 0, 0);

        // Wrap-around on the 8-bit instance; the 32-bit one carries into bit 8.
        applyStimulus(0, WORK, 1, 32'hFC, 1);
        checkState("toFC", 1, 32'hFC, 0, 0);
        checkOutput("smallFC", {24'b0, smallPcO}, 32'hFC);
        applyStimulus(0, WORK, 0, 0, 1);
        checkState("wide100", 1, 32'h100, 0, 0);
        checkOutput("smallWrap", {24'b0, smallPcO}, 32'h00);
        checkOutput("smallWrapValid", {31'b0, smallValidO}, 32'h1);
        checkOutput("smallWrapMis", {31'b0, smallMisO}, 32'h0);

        // Asynchronous reset in the middle of a cycle acts immediately.
        #3 rst = 1'b1;
        #1 checkState("asyncRst", 0, 32'h0, 0, 0);
        checkOutput("asyncRstSmall", {24'b0, smallPcO}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
